mem_arbiter: RTL
================

# mem_arbiter

Two-port memory controller between the MIPS core and the byte-wide `RAM` model. It arbitrates the instruction-fetch port against the data port and sequences each request into one or more `Enable`/`MOC` handshakes on the single RAM port. It assembles and splits 32-bit big-endian words across four byte accesses, then returns a one-cycle acknowledge to the winning requester.

## Interface
Parameters:
- `ADDR_W`, 9: RAM byte-address width (512 bytes).
- `WORD_BYTES`, 4: bytes per word access. Fixed at 4; other values are unsupported.

Ports:
- `Clk` in 1: single clock. Everything is rising-edge.
- `Reset` in 1: asynchronous, active-high.
- `IReq` in 1: fetch request. Always a word read.
- `IAddr` in ADDR_W: fetch byte address.
- `IRdata` out 32: fetched word. Valid while `IAck`=1.
- `IAck` out 1: fetch completion, one-cycle pulse.
- `DReq` in 1: data request.
- `DWe` in 1: 1 = write, 0 = read.
- `DSize` in 1: 0 = byte, 1 = word.
- `DAddr` in ADDR_W: data byte address.
- `DWdata` in 32: write data. A byte write uses `[7:0]`.
- `DRdata` out 32: read data. Byte reads are zero-extended. Valid while `DAck`=1.
- `DAck` out 1: data completion, one-cycle pulse.
- `DErr` out 1: pulses with `DAck` on a misaligned word access.
- `MemEnable` out 1: to RAM `Enable`.
- `MemMov` out 1: to RAM `MOV`. Equals `MemEnable`.
- `MemReadWrite` out 1: to RAM `ReadWrite`. 1 = read, 0 = write.
- `MemAddress` out ADDR_W: to RAM `Address`.
- `MemDataIn` out 8: to RAM `DataIn`.
- `MemDataOut` in 8: from RAM `DataOut`.
- `MemMoc` in 1: from RAM `MOC`.

## Operation
- States:
  - IDLE, GRANT, ISSUE, RELEASE, DONE.
  - ERR is a single-cycle path from GRANT to IDLE.
- IDLE:
  - `IReq`/`DReq` are sampled only in IDLE.
  - If either is high, latch the winner's address, direction, size and write data; clear byte counter `Cnt`; go to GRANT.
- GRANT:
  - Data word with `DAddr[1:0]`≠0: go to ERR. The RAM is not touched. ERR pulses `DAck`=`DErr`=1 and `DRdata`=0.
  - Otherwise go to ISSUE.
- ISSUE:
  - `MemEnable`=1. `MemAddress` = latched base address + `Cnt`.
  - `MemReadWrite` = ~we.
  - `MemDataIn` = byte `Cnt` of write word, big-endian: `Cnt`=0 selects `[31:24]`.
  - Hold until `MemMoc` is sampled 1.
  - On that edge, a read captures `MemDataOut` into byte `Cnt` of the shift/assembly register. Then go to RELEASE.
- RELEASE:
  - `MemEnable`=0. Hold until `MemMoc` is sampled 0.
  - If `Cnt` = last byte (0 for a byte access, 3 for a word), go to DONE.
  - Otherwise `Cnt`++ and go to ISSUE.
- DONE:
  - Pulse the owner's Ack for one cycle with read data valid, then return to IDLE.
- Requester rules:
  - Hold Req and all inputs stable until Ack.
  - Deassert Req in the Ack cycle. Req still high on the cycle after Ack is treated as a new request.
- Arbitration on simultaneous requests: data port wins (see Configuration).
- Address arithmetic is modulo 2^ADDR_W. Aligned words never wrap. A byte access at the top address is legal.

## Timing
- Reset values:
  - All outputs 0, state IDLE, `Cnt`=0.
  - Assertion mid-transaction drops `MemEnable` immediately (asynchronous) and abandons the request with no Ack.
- Latency with a RAM that answers `MemMoc` on the first sampled edge, counted from Req-high edge to Ack:
  - Byte access: 5 cycles (IDLE→GRANT→ISSUE→RELEASE→DONE).
  - Word access: 11 cycles.
  - Misaligned word: 3 cycles.
- Each added cycle of `MemMoc` delay in either direction adds one cycle per byte.
- Back-to-back: the earliest new grant is the cycle after DONE.
- `MemAddress`, `MemReadWrite`, `MemDataIn` are registered. They are stable for the whole ISSUE and RELEASE interval of a byte.

## Configuration
- `MEM_ARB_RR_EN`, defined: round-robin arbitration.
  - A one-bit last-granted pointer picks the port not served last on a tie.
  - The pointer resets to "fetch last", so the data port wins the first tie.
- `MEM_ARB_RR_EN`, undefined: fixed priority, data over fetch. Fetch can starve under continuous `DReq`.

## Structure
- Package `mem_arb_pkg`:
  - State enum.
  - `SIZE_BYTE`/`SIZE_WORD` codes.
  - `WORD_BYTES`.
  - Port-ID constants `PORT_I`/`PORT_D`.
- Sub-module `mem_byte_seq` owns the ISSUE/RELEASE handshake, byte counter and assembly register.
- The arbiter top owns IDLE/GRANT/DONE, the grant pointer and the requester muxing.

## Test plan
- RAM preloaded with bytes 0x12,0x34,0x56,0x78 at 0–3; `IReq` `IAddr`=0 → `IAck` after 11 cycles, `IRdata`=0x12345678, four Enable pulses at addresses 0,1,2,3.
- Data word write 0xDEADBEEF to 8, then data byte read of 9 → `DRdata`=0x000000AD; RAM bytes 8–11 = DE,AD,BE,EF.
- `DReq` word, `DAddr`=5 → `DAck`=`DErr`=1 in 3 cycles, `MemEnable` never rises.
- `IReq` and `DReq` high together on two successive transactions:
  - Without macro: data served both times.
  - With `MEM_ARB_RR_EN`: data, then fetch.
- `MemMoc` delayed 3 cycles on each edge for a byte read → `DAck` at 11 cycles, correct data.
- `Reset` pulsed during the third byte of a word read → `MemEnable` 0 same cycle, no Ack, next `IReq` completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter and its byte sequencer.
package mem_arb_pkg;

  localparam int   WORD_BYTES = 4;
  localparam logic SIZE_BYTE  = 1'b0;
  localparam logic SIZE_WORD  = 1'b1;
  localparam logic PORT_I     = 1'b0;
  localparam logic PORT_D     = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } arb_state_e;

  // Big-endian byte select: index 0 is the most significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer: runs one Enable/MOC handshake per byte, counts bytes and
// assembles big-endian read data.
module mem_byte_seq #(
  parameter int ADDR_W = 9
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              i_start,
  input  logic              i_we,
  input  logic [1:0]        i_last,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [31:0]       i_wdata,
  input  logic              i_moc,
  input  logic [7:0]        i_mem_dout,
  output logic              o_mem_en,
  output logic              o_mem_rw,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_din,
  output logic [31:0]       o_rdata,
  output logic              o_done
);
  import mem_arb_pkg::*;

  arb_state_e        r_phase;
  logic [1:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rw;
  logic [7:0]        r_din;
  logic [31:0]       r_asm;
  logic [1:0]        w_cnt_nxt;
  logic              w_rel_ok;

  assign w_cnt_nxt  = r_cnt + 2'd1;
  assign w_rel_ok   = (r_phase == ST_RELEASE) && !i_moc;
  assign o_done     = w_rel_ok && (r_cnt == i_last);
  assign o_mem_en   = (r_phase == ST_ISSUE);
  assign o_mem_rw   = r_rw;
  assign o_mem_addr = r_addr;
  assign o_mem_din  = r_din;
  assign o_rdata    = r_asm;

  // Address/direction/data are loaded as a byte's ISSUE begins so they hold through RELEASE.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_phase <= ST_IDLE;
      r_cnt   <= 2'd0;
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_din   <= 8'h00;
    end else begin
      case (r_phase)
        ST_IDLE: begin
          if (i_start) begin
            r_phase <= ST_ISSUE;
            r_cnt   <= 2'd0;
            r_addr  <= i_base;
            r_rw    <= ~i_we;
            r_din   <= word_byte(i_wdata, 2'd0);
          end
        end
        ST_ISSUE: begin
          if (i_moc) r_phase <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (w_rel_ok) begin
            if (r_cnt == i_last) begin
              r_phase <= ST_IDLE;
            end else begin
              r_phase <= ST_ISSUE;
              r_cnt   <= w_cnt_nxt;
              r_addr  <= i_base + ADDR_W'(w_cnt_nxt);
              r_din   <= word_byte(i_wdata, w_cnt_nxt);
            end
          end
        end
        default: r_phase <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if ((r_phase == ST_ISSUE) && i_moc && r_rw) begin
      case (r_cnt)
        2'd0:    r_asm[31:24] <= i_mem_dout;
        2'd1:    r_asm[23:16] <= i_mem_dout;
        2'd2:    r_asm[15:8]  <= i_mem_dout;
        default: r_asm[7:0]   <= i_mem_dout;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a byte-wide RAM with Enable/MOC handshake.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise data beats fetch.
module mem_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int WORD_BYTES = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic [31:0]       IRdata,
  output logic              IAck,
  input  logic              DReq,
  input  logic              DWe,
  input  logic              DSize,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [31:0]       DWdata,
  output logic [31:0]       DRdata,
  output logic              DAck,
  output logic              DErr,
  output logic              MemEnable,
  output logic              MemMov,
  output logic              MemReadWrite,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [7:0]        MemDataIn,
  input  logic [7:0]        MemDataOut,
  input  logic              MemMoc
);
  import mem_arb_pkg::*;

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  arb_state_e        r_state;
  logic              r_owner;
  logic              r_we;
  logic              r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              w_pick_d;
  logic              w_err;
  logic              w_start;
  logic              w_seq_done;
  logic [31:0]       w_asm;
  logic [1:0]        w_last;
  logic              w_d_done;

`ifdef MEM_ARB_RR_EN
  logic r_last;

  // Tie goes to whichever port was not granted last; reset state favours data.
  assign w_pick_d = DReq && (!IReq || (r_last == PORT_I));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_last <= PORT_I;
    else if ((r_state == ST_IDLE) && (IReq || DReq)) r_last <= w_pick_d ? PORT_D : PORT_I;
  end
`else
  assign w_pick_d = DReq;
`endif

  assign w_err   = (r_owner == PORT_D) && (r_size == SIZE_WORD) && (r_addr[1:0] != 2'b00);
  assign w_start = (r_state == ST_GRANT) && !w_err;
  assign w_last  = (r_size == SIZE_WORD) ? LAST_IDX : 2'd0;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_owner <= PORT_I;
      r_we    <= 1'b0;
      r_size  <= SIZE_BYTE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (IReq || DReq) begin
            r_state <= ST_GRANT;
            r_owner <= w_pick_d ? PORT_D : PORT_I;
            r_we    <= w_pick_d && DWe;
            r_size  <= w_pick_d ? DSize : SIZE_WORD;
          end
        end
        ST_GRANT: r_state <= w_err ? ST_ERR : ST_ISSUE;
        ST_ISSUE: begin
          if (w_seq_done) r_state <= ST_DONE;
        end
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Byte writes are pre-placed in the top byte so the sequencer always starts at index 0.
  always_ff @(posedge Clk) begin
    if ((r_state == ST_IDLE) && (IReq || DReq)) begin
      r_addr  <= w_pick_d ? DAddr : IAddr;
      r_wdata <= DSize ? DWdata : {DWdata[7:0], 24'h000000};
    end
  end

  mem_byte_seq #(.ADDR_W(ADDR_W)) u_seq (
    .Clk        (Clk),
    .Reset      (Reset),
    .i_start    (w_start),
    .i_we       (r_we),
    .i_last     (w_last),
    .i_base     (r_addr),
    .i_wdata    (r_wdata),
    .i_moc      (MemMoc),
    .i_mem_dout (MemDataOut),
    .o_mem_en   (MemEnable),
    .o_mem_rw   (MemReadWrite),
    .o_mem_addr (MemAddress),
    .o_mem_din  (MemDataIn),
    .o_rdata    (w_asm),
    .o_done     (w_seq_done)
  );

  assign MemMov   = MemEnable;
  assign w_d_done = (r_state == ST_DONE) && (r_owner == PORT_D);
  assign IAck     = (r_state == ST_DONE) && (r_owner == PORT_I);
  assign DAck     = w_d_done || (r_state == ST_ERR);
  assign DErr     = (r_state == ST_ERR);
  assign IRdata   = IAck ? w_asm : 32'h0;
  assign DRdata   = (w_d_done && !r_we) ?
                    ((r_size == SIZE_WORD) ? w_asm : {24'h000000, w_asm[31:24]}) : 32'h0;

endmodule
